// File: rtl/encoder42_pkg.sv
// Shared constants and helpers for the 4-line encoder/decoder pair.
// Exports N (lines), W (code width) and onehot4() for 2-bit indices.
package encoder42_pkg;

    localparam int N = 4;
    localparam int W = 2;

    // One-hot expansion of a 2-bit index (also the 2-to-4 decode).
    function automatic logic [N-1:0] onehot4(input logic [W-1:0] idx);
        logic [N-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/encoder42_rr_pick4.sv
// Combinational round-robin picker over four pending bits.
// Ports: pend, ptr in; sel (first set bit from ptr upward, mod 4), found out.
module rr_pick4
    import encoder42_pkg::*;
(
    input  logic [N-1:0] pend,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] sel,
    output logic         found
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   off;

    // rot[k] is pend[(ptr+k) mod 4], so lowest set bit of rot is the winner.
    assign dbl = {pend, pend};
    assign rot = dbl[ptr +: N];

    always_comb begin
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = W'(k);
            end
        end
    end

    // Un-rotate: 2-bit addition wraps naturally.
    assign sel   = ptr + off;
    assign found = |pend;

endmodule

// File: rtl/encoder42_rr.sv
// Sequential 4-to-2 encoder: sticky per-line requests, round-robin grant,
// registered valid/ready code output.
// Ports: clk, rst_n (async low), i[3:0] requests, z[1:0]/z_valid/z_ready
// output handshake, busy = any pending event or held code.
module encoder42_rr
    import encoder42_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i,
    output logic [W-1:0] z,
    output logic         z_valid,
    input  logic         z_ready,
    output logic         busy
);

    logic [N-1:0] pend;
    logic [W-1:0] ptr;
    logic [W-1:0] sel;
    logic         found;
    logic         slot_free;
    logic         load;
    logic [N-1:0] load_mask;

    rr_pick4 u_pick (
        .pend  (pend),
        .ptr   (ptr),
        .sel   (sel),
        .found (found)
    );

    assign slot_free = !z_valid || z_ready;
    assign load      = slot_free && found;
    assign load_mask = load ? onehot4(sel) : '0;

    // A line re-asserted while being loaded stays pending as a new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~load_mask) | i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            z       <= '0;
            z_valid <= 1'b0;
        end else if (slot_free) begin
            if (found) begin
                z       <= sel;
                z_valid <= 1'b1;
                ptr     <= sel + 1'b1;
            end else begin
                z_valid <= 1'b0;
            end
        end
    end

    assign busy = (|pend) || z_valid;

endmodule

// File: tb/tb_encoder42_rr.sv
// Randomized self-checking bench for encoder42_rr against a
// set-of-pending-lines reference model.
module tb_encoder42_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] i;
    logic [1:0] z;
    logic       z_valid;
    logic       z_ready;
    logic       busy;

    int total;
    int passed;

    // Reference model: which lines have an outstanding event, where the
    // round-robin search starts, and what the consumer currently sees.
    bit mp[4];
    int mptr;
    bit mv;
    int mz;

    encoder42_rr dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i),
        .z       (z),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit mbusy();
        return mp[0] || mp[1] || mp[2] || mp[3] || mv;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) mp[k] = 0;
        mptr = 0;
        mv = 0;
        mz = 0;
    endtask

    task automatic model_edge(input logic [3:0] req, input logic rdy);
        int  pick;
        pick = -1;
        for (int k = 0; k < 4; k++) begin
            if (pick < 0 && mp[(mptr + k) % 4]) pick = (mptr + k) % 4;
        end
        if (!mv || rdy) begin
            if (pick >= 0) begin
                mz = pick;
                mv = 1;
                mptr = (pick + 1) % 4;
                mp[pick] = 0;
            end else begin
                mv = 0;
            end
        end
        for (int k = 0; k < 4; k++) if (req[k]) mp[k] = 1;
    endtask

    // Drive one cycle of inputs, advance the model, settle past the edge.
    task automatic step(input logic [3:0] req, input logic rdy);
        @(negedge clk);
        i = req;
        z_ready = rdy;
        @(posedge clk);
        model_edge(req, rdy);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i = '0;
        z_ready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i = 4'($urandom);
            z_ready = 1'($urandom);
            @(posedge clk);
            #1;
            total++;
            if (z_valid !== 1'b0 || z !== 2'd0 || busy !== 1'b0)
                $display("FAIL reset_hold: v=%b z=%0d busy=%b want 0/0/0",
                         z_valid, z, busy);
            else passed++;
        end
        @(negedge clk);
        i = '0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(4'b0000, 1'b1);
            total++;
            if (z_valid !== 1'b0 || z !== 2'd0 || busy !== 1'b0)
                $display("FAIL reset_release: v=%b z=%0d busy=%b want 0/0/0",
                         z_valid, z, busy);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [2:0] want_v;
        want_v = 3'b010;
        do_reset();
        step(4'b0100, 1'b1);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (z_valid !== want_v[c])
                $display("FAIL single_lat c%0d: v=%b want %b",
                         c, z_valid, want_v[c]);
            else passed++;
            if (c == 1) begin
                total++;
                if (z !== 2'd2)
                    $display("FAIL single_code: z=%0d want 2", z);
                else passed++;
            end
            if (c < 2) step(4'b0000, 1'b1);
        end
        total++;
        if (busy !== 1'b0)
            $display("FAIL single_idle: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_burst();
        do_reset();
        step(4'b1111, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step(4'b0000, 1'b1);
            total++;
            if (z_valid !== 1'b1 || z !== 2'(c) || z !== 2'(mz))
                $display("FAIL burst_%0d: v=%b z=%0d want 1/%0d",
                         c, z_valid, z, c);
            else passed++;
        end
        step(4'b0000, 1'b1);
        total++;
        if (z_valid !== 1'b0 || busy !== 1'b0 || mptr != 0)
            $display("FAIL burst_end: v=%b busy=%b want 0/0", z_valid, busy);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [3:0] pulses;
        int n3;
        pulses = 4'b1011;
        do_reset();
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(pulses[c] ? 4'b1000 : 4'b0000, 1'b0);
            total++;
            if (z_valid !== 1'b1 || z !== 2'd3)
                $display("FAIL bp_hold_%0d: v=%b z=%0d want 1/3",
                         c, z_valid, z);
            else passed++;
        end
        // Release: held code plus the one coalesced re-post, nothing more.
        n3 = 0;
        for (int c = 0; c < 4; c++) begin
            if (z_valid === 1'b1 && z === 2'd3) n3++;
            step(4'b0000, 1'b1);
        end
        total++;
        if (n3 != 2 || z_valid !== 1'b0)
            $display("FAIL bp_coalesce: transfers=%0d want 2", n3);
        else passed++;
        // Re-post line 3 on the very edge that loads it.
        step(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        total++;
        if (z_valid !== 1'b1 || z !== 2'd3)
            $display("FAIL bp_reload: v=%b z=%0d want 1/3", z_valid, z);
        else passed++;
        step(4'b0000, 1'b1);
        total++;
        if (z_valid !== mv || z !== 2'(mz) || busy !== mbusy())
            $display("FAIL bp_tail: v=%b z=%0d want %b/%0d",
                     z_valid, z, mv, mz);
        else passed++;
    endtask

    task automatic test_wrap();
        logic [3:0] order;
        do_reset();
        step(4'b1000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1001, 1'b1);
        order = {2'd3, 2'd0};
        for (int c = 0; c < 2; c++) begin
            step(4'b0000, 1'b1);
            total++;
            if (z_valid !== 1'b1 || z !== order[2*c +: 2])
                $display("FAIL wrap_p0_%0d: v=%b z=%0d want 1/%0d",
                         c, z_valid, z, order[2*c +: 2]);
            else passed++;
        end
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b1001, 1'b1);
        order = {2'd0, 2'd3};
        for (int c = 0; c < 2; c++) begin
            step(4'b0000, 1'b1);
            total++;
            if (z_valid !== 1'b1 || z !== order[2*c +: 2])
                $display("FAIL wrap_p1_%0d: v=%b z=%0d want 1/%0d",
                         c, z_valid, z, order[2*c +: 2]);
            else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (z_valid !== 1'b0 || busy !== 1'b0 || z !== 2'd0)
            $display("FAIL async_rst: v=%b busy=%b z=%0d want 0/0/0",
                     z_valid, busy, z);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(4'b0000, 1'b1);
            total++;
            if (z_valid !== 1'b0 || busy !== 1'b0)
                $display("FAIL async_after_%0d: v=%b busy=%b want 0/0",
                         c, z_valid, busy);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        int errs;
        do_reset();
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            step(req, 1'($urandom_range(0, 3) != 0));
            total++;
            if (z_valid !== mv || z !== 2'(mz) || busy !== mbusy()) begin
                if (errs < 10)
                    $display("FAIL random_%0d: v=%b z=%0d busy=%b want %b/%0d/%b",
                             c, z_valid, z, busy, mv, mz, mbusy());
                errs++;
            end else passed++;
        end
    endtask

    initial begin
        total = 0;
        passed = 0;
        rst_n = 1'b0;
        i = '0;
        z_ready = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
